// File: rtl/exe_mem_stage_reg.sv
// rtl/exe_mem_stage_reg.sv - EXE->MEM pipeline register with CPSR flags and retired-instruction counter
// Optional feature macro: STATUS_BYPASS_EN (combinational flag forward to the ID stage)
module exe_mem_stage_reg #(
   parameter int DW   = 32,
   parameter int RW   = 4,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            freeze,
   input  logic            flush,
   input  logic            in_valid,
   input  logic [DW-1:0]   alu_res,
   input  logic [DW-1:0]   st_val,
   input  logic [RW-1:0]   dest,
   input  logic            wb_en,
   input  logic            mem_r_en,
   input  logic            mem_w_en,
   input  logic            s_en,
   input  logic            n_in,
   input  logic            z_in,
   input  logic            c_in,
   input  logic            v_in,
   output logic            out_valid,
   output logic [DW-1:0]   alu_res_q,
   output logic [DW-1:0]   st_val_q,
   output logic [RW-1:0]   dest_q,
   output logic            wb_en_q,
   output logic            mem_r_en_q,
   output logic            mem_w_en_q,
   output logic [3:0]      status,
   output logic [3:0]      status_fwd,
   output logic            c_to_alu,
   output logic [CNTW-1:0] instr_cnt
);

   logic            valid_q, valid_d;
   logic [DW-1:0]   alu_res_d;
   logic [DW-1:0]   st_val_d;
   logic [RW-1:0]   dest_d;
   logic            wb_en_d, mem_r_en_d, mem_w_en_d;
   logic [3:0]      status_q, status_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            accept;
   logic [3:0]      flags_in;

   // An S-bit instruction that actually enters MEM is the only thing allowed to touch the flags
   always_comb begin
      flags_in = {n_in, z_in, c_in, v_in};
      accept   = in_valid & s_en & ~freeze & ~flush;
   end

   // Next-state selection: freeze holds everything, flush inserts a bubble, otherwise capture EXE
   always_comb begin
      valid_d    = valid_q;
      alu_res_d  = alu_res_q;
      st_val_d   = st_val_q;
      dest_d     = dest_q;
      wb_en_d    = wb_en_q;
      mem_r_en_d = mem_r_en_q;
      mem_w_en_d = mem_w_en_q;
      status_d   = status_q;
      cnt_d      = cnt_q;
      if (!freeze) begin
         if (flush) begin
            // data fields are don't-care in a bubble, so they simply hold
            valid_d    = 1'b0;
            wb_en_d    = 1'b0;
            mem_r_en_d = 1'b0;
            mem_w_en_d = 1'b0;
         end else begin
            valid_d    = in_valid;
            alu_res_d  = alu_res;
            st_val_d   = st_val;
            dest_d     = dest;
            wb_en_d    = wb_en & in_valid;
            mem_r_en_d = mem_r_en & in_valid;
            mem_w_en_d = mem_w_en & in_valid;
            if (in_valid) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
      if (accept) begin
         status_d = flags_in;
      end
   end

   // Pipeline, status and counter registers with synchronous reset taking priority over freeze
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         alu_res_q  <= '0;
         st_val_q   <= '0;
         dest_q     <= '0;
         wb_en_q    <= 1'b0;
         mem_r_en_q <= 1'b0;
         mem_w_en_q <= 1'b0;
         status_q   <= 4'b0000;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         alu_res_q  <= alu_res_d;
         st_val_q   <= st_val_d;
         dest_q     <= dest_d;
         wb_en_q    <= wb_en_d;
         mem_r_en_q <= mem_r_en_d;
         mem_w_en_q <= mem_w_en_d;
         status_q   <= status_d;
         cnt_q      <= cnt_d;
      end
   end

   // Output mapping; the ALU carry-in always comes from registered flags to keep its path short
   always_comb begin
      out_valid = valid_q;
      status    = status_q;
      c_to_alu  = status_q[1];
      instr_cnt = cnt_q;
`ifdef STATUS_BYPASS_EN
      status_fwd = accept ? flags_in : status_q;
`else
      status_fwd = status_q;
`endif
   end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// tb/tb_exe_mem_stage_reg.sv - randomized self-checking bench for exe_mem_stage_reg
module tb_exe_mem_stage_reg;

   localparam int DW = 32, RW = 4, CNTW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, freeze, flush, in_valid, wb_en, mem_r_en, mem_w_en, s_en;
   logic n_in, z_in, c_in, v_in;
   logic [DW-1:0] alu_res, st_val;
   logic [RW-1:0] dest;
   logic out_valid, wb_en_q, mem_r_en_q, mem_w_en_q, c_to_alu;
   logic [DW-1:0] alu_res_q, st_val_q;
   logic [RW-1:0] dest_q;
   logic [3:0] status, status_fwd;
   logic [CNTW-1:0] instr_cnt;

   exe_mem_stage_reg #(.DW(DW), .RW(RW), .CNTW(CNTW)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
      .alu_res(alu_res), .st_val(st_val), .dest(dest), .wb_en(wb_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .s_en(s_en),
      .n_in(n_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
      .out_valid(out_valid), .alu_res_q(alu_res_q), .st_val_q(st_val_q), .dest_q(dest_q),
      .wb_en_q(wb_en_q), .mem_r_en_q(mem_r_en_q), .mem_w_en_q(mem_w_en_q),
      .status(status), .status_fwd(status_fwd), .c_to_alu(c_to_alu), .instr_cnt(instr_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference view of the MEM slot, as a record of "what instruction is sitting there"
   typedef struct {
      bit            valid;
      bit [DW-1:0]   res;
      bit [DW-1:0]   sv;
      bit [RW-1:0]   rd;
      bit            wb, ld, st;
   } slot_t;
   slot_t      m_slot;
   bit [3:0]   m_flags;
   int unsigned m_retired;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      rst = 0; freeze = 0; flush = 0; in_valid = 0; wb_en = 0; mem_r_en = 0; mem_w_en = 0;
      s_en = 0; n_in = 0; z_in = 0; c_in = 0; v_in = 0; alu_res = '0; st_val = '0; dest = '0;
   endtask

   task automatic check_outputs();
      check("out_valid", out_valid, m_slot.valid);
      if (m_slot.valid) begin
         check("alu_res_q", alu_res_q, m_slot.res);
         check("st_val_q", st_val_q, m_slot.sv);
         check("dest_q", dest_q, m_slot.rd);
      end
      check("wb_en_q", wb_en_q, m_slot.valid & m_slot.wb);
      check("mem_r_en_q", mem_r_en_q, m_slot.valid & m_slot.ld);
      check("mem_w_en_q", mem_w_en_q, m_slot.valid & m_slot.st);
      check("status", status, m_flags);
      check("c_to_alu", c_to_alu, m_flags[1]);
      check("instr_cnt", instr_cnt, m_retired % (1 << CNTW));
   endtask

   // apply the current inputs for one clock, predict the result, and compare
   task automatic step();
      bit moves, takes_flags;
      bit [3:0] exp_fwd;
      #2;
      moves       = !freeze && !flush;
      takes_flags = moves && in_valid && s_en;
`ifdef STATUS_BYPASS_EN
      exp_fwd = takes_flags ? {n_in, z_in, c_in, v_in} : m_flags;
`else
      exp_fwd = m_flags;
`endif
      if (!rst) check("status_fwd", status_fwd, exp_fwd);
      @(posedge clk);
      if (rst) begin
         m_slot = '{default: 0};
         m_flags = 4'b0000;
         m_retired = 0;
      end else if (!freeze) begin
         if (takes_flags) m_flags = {n_in, z_in, c_in, v_in};
         if (flush) begin
            m_slot.valid = 0;
         end else begin
            m_slot = '{valid: in_valid, res: alu_res, sv: st_val, rd: dest,
                       wb: wb_en, ld: mem_r_en, st: mem_w_en};
            if (in_valid) m_retired++;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic randomize_inputs(input bit allow_ctrl);
      rst      = allow_ctrl && ($urandom_range(0, 39) == 0);
      freeze   = allow_ctrl && ($urandom_range(0, 4) == 0);
      flush    = allow_ctrl && ($urandom_range(0, 5) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      wb_en = $urandom; mem_r_en = $urandom; mem_w_en = $urandom; s_en = $urandom;
      n_in = $urandom; z_in = $urandom; c_in = $urandom; v_in = $urandom;
      alu_res = $urandom; st_val = $urandom; dest = $urandom;
   endtask

   initial begin
      idle_inputs();
      m_slot = '{default: 0};
      m_flags = 0;
      m_retired = 0;
      @(posedge clk); #1;

      // reset then idle
      rst = 1; step();
      rst = 0; step();
      check("reset_status", status, 4'b0000);
      check("reset_cnt", instr_cnt, 16'd0);

      // simple pipe of a write-back instruction
      in_valid = 1; alu_res = 32'h0000_00A5; dest = 3; wb_en = 1; step();
      check("pipe_res", alu_res_q, 32'h0000_00A5);
      check("pipe_cnt", instr_cnt, 16'd1);

      // CMP: flags update without write-back, then an S=0 instruction leaves them alone
      wb_en = 0; s_en = 1; z_in = 1; c_in = 1; step();
      check("cmp_status", status, 4'b0110);
      check("cmp_carry", c_to_alu, 1'b1);
      s_en = 0; n_in = 1; z_in = 0; c_in = 0; step();
      check("hold_status", status, 4'b0110);

      // freeze for three cycles with changing inputs, flush raised in the middle
      in_valid = 1; wb_en = 1; alu_res = 32'h1234_5678; dest = 7; step();
      for (int i = 0; i < 3; i++) begin
         freeze = 1; flush = (i == 1); s_en = 1;
         alu_res = $urandom; dest = $urandom; {n_in, z_in, c_in, v_in} = 4'($urandom);
         step();
      end
      check("freeze_res", alu_res_q, 32'h1234_5678);
      freeze = 0; flush = 0;

      // flush kills a store with S set
      flush = 1; in_valid = 1; mem_w_en = 1; s_en = 1; {n_in, z_in, c_in, v_in} = ~m_flags; step();
      check("flush_valid", out_valid, 1'b0);
      check("flush_wen", mem_w_en_q, 1'b0);
      flush = 0;

      // randomized traffic, including resets during freeze
      for (int i = 0; i < 600; i++) begin
         randomize_inputs(1'b1);
         step();
      end
      idle_inputs();

      // drive the counter to its top value, then one more accept must wrap it
      while ((m_retired % (1 << CNTW)) != 16'hFFFF) begin
         randomize_inputs(1'b0);
         in_valid = 1;
         step();
      end
      check("cnt_top", instr_cnt, 16'hFFFF);
      randomize_inputs(1'b0);
      in_valid = 1; s_en = 1; {n_in, z_in, c_in, v_in} = ~m_flags;
      step();
      check("cnt_wrap", instr_cnt, 16'h0000);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
